// File: rtl/sh_mem_banked_rr.sv
// Banked shared memory: requests steered by upper address bits, each bank
// arbitrated by its own round-robin pointer; saturating conflict counter.
module sh_mem_banked_rr #(
    parameter int NUM_CORES   = 16,
    parameter int DATA_W      = 8,
    parameter int BANK_BITS   = 4,
    parameter int OFFSET_BITS = 8,
    parameter int CNT_W       = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [2*NUM_CORES-1:0]                       enable,
    input  logic [(BANK_BITS+OFFSET_BITS)*NUM_CORES-1:0] addr,
    input  logic [DATA_W*NUM_CORES-1:0]                  wr_data,
    output logic [DATA_W*NUM_CORES-1:0]                  rd_data,
    output logic [NUM_CORES-1:0]                         ready,
    output logic [CNT_W-1:0]                             conflict_cnt
);
    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int DEPTH     = 2 ** OFFSET_BITS;
    localparam int ADDR_W    = BANK_BITS + OFFSET_BITS;
    localparam int CI_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int ADD_W     = $clog2(NUM_CORES + 1);

    logic [DATA_W-1:0]      mem_q [NUM_BANKS][DEPTH];
    logic [CI_W-1:0]        ptr_q [NUM_BANKS];
    logic [CI_W-1:0]        ptr_d [NUM_BANKS];
    logic [NUM_CORES-1:0]   ready_q, ready_d;
    logic [DATA_W*NUM_CORES-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_CORES-1:0]   req, is_wr, gnt;
    logic [BANK_BITS-1:0]   bank [NUM_CORES];
    logic [OFFSET_BITS-1:0] off [NUM_CORES];
    logic [NUM_BANKS-1:0]   gvld, bwe;
    logic [CI_W-1:0]        gidx [NUM_BANKS];
    logic [OFFSET_BITS-1:0] boff [NUM_BANKS];
    logic [DATA_W-1:0]      bwd [NUM_BANKS];
    logic [CI_W-1:0]        idx_c;
    logic [ADD_W-1:0]       n_deny;
    logic [CNT_W+ADD_W-1:0] cnt_sum;

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            req[c]   = (enable[2*c +: 2] == 2'b01) || (enable[2*c +: 2] == 2'b10);
            is_wr[c] = (enable[2*c +: 2] == 2'b10);
            bank[c]  = addr[c*ADDR_W+OFFSET_BITS +: BANK_BITS];
            off[c]   = addr[c*ADDR_W +: OFFSET_BITS];
        end
    end

    // Per bank: scan cores starting at the pointer, first candidate wins.
    always_comb begin
        gnt   = '0;
        idx_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gvld[b] = 1'b0;
            gidx[b] = '0;
            bwe[b]  = 1'b0;
            boff[b] = '0;
            bwd[b]  = '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                idx_c = CI_W'((int'(ptr_q[b]) + k) % NUM_CORES);
                if (!gvld[b] && req[idx_c] && bank[idx_c] == BANK_BITS'(b)) begin
                    gvld[b]    = 1'b1;
                    gidx[b]    = idx_c;
                    gnt[idx_c] = 1'b1;
                    bwe[b]     = is_wr[idx_c];
                    boff[b]    = off[idx_c];
                    bwd[b]     = wr_data[int'(idx_c)*DATA_W +: DATA_W];
                end
            end
            if (!gvld[b])
                ptr_d[b] = ptr_q[b];
            else if (gidx[b] == CI_W'(NUM_CORES - 1))
                ptr_d[b] = '0;
            else
                ptr_d[b] = gidx[b] + 1'b1;
        end
    end

    always_comb begin
        ready_d = gnt;
        rd_d    = rd_q;
        n_deny  = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (gnt[c] && !is_wr[c])
                rd_d[c*DATA_W +: DATA_W] = mem_q[bank[c]][off[c]];
            n_deny = n_deny + ADD_W'(req[c] && !gnt[c]);
        end
        cnt_sum = {{ADD_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, n_deny};
        if (cnt_sum > {{ADD_W{1'b0}}, {CNT_W{1'b1}}})
            cnt_d = {CNT_W{1'b1}};
        else
            cnt_d = cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int b = 0; b < NUM_BANKS; b++)
                ptr_q[b] <= '0;
        end else begin
            ready_q <= ready_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            for (int b = 0; b < NUM_BANKS; b++)
                ptr_q[b] <= ptr_d[b];
        end
    end

    // Storage is not reset, but a write landing while reset is held is dropped.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            if (!reset && bwe[b])
                mem_q[b][boff[b]] <= bwd[b];
    end

    assign ready        = ready_q;
    assign rd_data      = rd_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sh_mem_banked_rr.sv
// Bench for sh_mem_banked_rr: vector table, directed sequences and random
// traffic compared against a behavioural model of the banked memory.
module tb_sh_mem_banked_rr;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 12;

    logic           clk = 0;
    logic           reset;
    logic [2*N-1:0] en;
    logic [AW*N-1:0] ad;
    logic [DW*N-1:0] wd;
    logic [DW*N-1:0] rd;
    logic [N-1:0]   rdy;
    logic [15:0]    cnt;

    sh_mem_banked_rr dut (
        .clk(clk), .reset(reset), .enable(en), .addr(ad),
        .wr_data(wd), .rd_data(rd), .ready(rdy), .conflict_cnt(cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference state
    int         m_ptr [N];
    logic [7:0] m_mem [int];
    logic [7:0] m_rd  [N];
    bit         m_kn  [N];
    logic [N-1:0] m_rdy;
    int         m_cnt;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ptr[i] = 0;
            m_rd[i]  = 8'h00;
            m_kn[i]  = 1'b1;
        end
        m_rdy = '0;
        m_cnt = 0;
    endtask

    // One clock edge of the shared memory, from the request rules.
    task automatic model_edge();
        logic [N-1:0] g;
        int nreq, ngnt, best, bd, d, key;
        logic [1:0] op;
        g = '0;
        nreq = 0;
        ngnt = 0;
        for (int c = 0; c < N; c++) begin
            op = en[2*c +: 2];
            if (op == 2'b01 || op == 2'b10) nreq++;
        end
        for (int b = 0; b < N; b++) begin
            best = -1;
            bd = N;
            for (int c = 0; c < N; c++) begin
                op = en[2*c +: 2];
                if ((op == 2'b01 || op == 2'b10) && int'(ad[c*AW+8 +: 4]) == b) begin
                    d = (c - m_ptr[b] + N) % N;
                    if (d < bd) begin
                        bd = d;
                        best = c;
                    end
                end
            end
            if (best >= 0) begin
                g[best] = 1'b1;
                ngnt++;
                key = b * 256 + int'(ad[best*AW +: 8]);
                if (en[2*best +: 2] == 2'b01) begin
                    if (m_mem.exists(key)) begin
                        m_rd[best] = m_mem[key];
                        m_kn[best] = 1'b1;
                    end else begin
                        m_kn[best] = 1'b0;
                    end
                end else begin
                    m_mem[key] = wd[best*DW +: DW];
                end
                m_ptr[b] = (best + 1) % N;
            end
        end
        m_rdy = g;
        m_cnt = m_cnt + nreq - ngnt;
        if (m_cnt > 65535) m_cnt = 65535;
    endtask

    task automatic step();
        logic [127:0] exp_rd, mask;
        model_edge();
        @(posedge clk);
        #1;
        exp_rd = '0;
        mask = '0;
        for (int c = 0; c < N; c++)
            if (m_kn[c]) begin
                exp_rd[c*DW +: DW] = m_rd[c];
                mask[c*DW +: DW] = 8'hFF;
            end
        chk("model_ready", 128'(rdy), 128'(m_rdy));
        chk("model_rd_data", 128'(rd) & mask, exp_rd);
        chk("model_cnt", 128'(cnt), 128'(m_cnt));
    endtask

    task automatic set_req(int c, logic [1:0] op, int b, int o, logic [7:0] d);
        en[2*c +: 2]  = op;
        ad[c*AW +: AW] = {4'(b), 8'(o)};
        wd[c*DW +: DW] = d;
    endtask

    task automatic idle_all();
        en = '0;
        ad = '0;
        wd = '0;
    endtask

    typedef struct {
        int         core;
        logic [1:0] op;
        int         bank;
        int         off;
        logic [7:0] wdat;
        logic       exp_rdy;
        logic [7:0] exp_rd;
        bit         chk_rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{2, 2'b10, 5, 123, 8'd45, 1'b1, 8'd0,  1'b0};
        tbl[1] = '{2, 2'b01, 5, 123, 8'd0,  1'b1, 8'd45, 1'b1};
        tbl[2] = '{2, 2'b10, 5, 123, 8'd76, 1'b1, 8'd45, 1'b1};
        tbl[3] = '{2, 2'b01, 5, 123, 8'd0,  1'b1, 8'd76, 1'b1};
        tbl[4] = '{4, 2'b10, 8, 23,  8'd67, 1'b1, 8'd0,  1'b0};
        tbl[5] = '{4, 2'b00, 8, 23,  8'd0,  1'b0, 8'd0,  1'b0};
        tbl[6] = '{4, 2'b01, 8, 23,  8'd0,  1'b1, 8'd67, 1'b1};
        tbl[7] = '{4, 2'b11, 8, 23,  8'd0,  1'b0, 8'd67, 1'b1};

        idle_all();
        reset = 1'b1;
        model_reset();
        #12;
        chk("reset_ready", 128'(rdy), 128'(0));
        chk("reset_rd", 128'(rd), 128'(0));
        chk("reset_cnt", 128'(cnt), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three writers to bank 8, each dropping out once served
        set_req(1, 2'b10, 8, 1, 8'h11);
        set_req(3, 2'b10, 8, 3, 8'h33);
        set_req(7, 2'b10, 8, 7, 8'h77);
        step();
        chk("rr3_rdy1", 128'(rdy), 128'(16'h0002));
        chk("rr3_cnt1", 128'(cnt), 128'(2));
        set_req(1, 2'b00, 0, 0, 8'h00);
        step();
        chk("rr3_rdy3", 128'(rdy), 128'(16'h0008));
        chk("rr3_cnt2", 128'(cnt), 128'(3));
        set_req(3, 2'b00, 0, 0, 8'h00);
        step();
        chk("rr3_rdy7", 128'(rdy), 128'(16'h0080));
        chk("rr3_cnt3", 128'(cnt), 128'(3));
        idle_all();
        step();
        chk("rr3_idle", 128'(rdy), 128'(0));

        // Different banks complete in parallel
        set_req(0, 2'b10, 0, 5, 8'hA0);
        set_req(1, 2'b10, 1, 5, 8'hA1);
        step();
        chk("par_rdy", 128'(rdy), 128'(16'h0003));
        chk("par_cnt", 128'(cnt), 128'(3));
        idle_all();

        // Cores 0 and 15 back-to-back on bank 2: strict alternation
        set_req(0, 2'b01, 2, 0, 8'h00);
        set_req(15, 2'b01, 2, 1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_rdy", 128'(rdy), 128'((i % 2 == 0) ? 16'h0001 : 16'h8000));
            chk("alt_cnt", 128'(cnt), 128'(4 + i));
        end
        idle_all();
        step();

        // Single-core vector table
        foreach (tbl[i]) begin
            idle_all();
            set_req(tbl[i].core, tbl[i].op, tbl[i].bank, tbl[i].off, tbl[i].wdat);
            step();
            chk("tbl_rdy", 128'(rdy), 128'(16'(tbl[i].exp_rdy) << tbl[i].core));
            if (tbl[i].chk_rd)
                chk("tbl_rd", 128'(rd[tbl[i].core*DW +: DW]), 128'(tbl[i].exp_rd));
        end
        idle_all();
        step();

        // Random contention on a few banks/offsets
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++)
                set_req(c, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                        $urandom_range(0, 3), 8'($urandom));
            step();
        end
        idle_all();
        step();

        // Everyone hammers bank 7 until the counter saturates
        for (int c = 0; c < N; c++)
            set_req(c, 2'b01, 7, c, 8'h00);
        for (int i = 0; i < 4500; i++)
            step();
        chk("sat_cnt", 128'(cnt), 128'(16'hFFFF));
        idle_all();
        step();
        chk("sat_hold", 128'(cnt), 128'(16'hFFFF));

        // Reset colliding with a granted write
        set_req(5, 2'b10, 3, 10, 8'd11);
        step();
        set_req(5, 2'b10, 3, 10, 8'd99);
        set_req(6, 2'b01, 7, 0, 8'h00);
        set_req(9, 2'b01, 7, 1, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_rdy", 128'(rdy), 128'(0));
        chk("rst_mid_cnt", 128'(cnt), 128'(0));
        chk("rst_mid_rd", 128'(rd), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle_all();
        step();
        chk("rst_rel_rdy", 128'(rdy), 128'(0));
        set_req(5, 2'b01, 3, 10, 8'h00);
        step();
        chk("rst_rd_old", 128'(rd[5*DW +: DW]), 128'(8'd11));
        chk("rst_rd_rdy", 128'(rdy), 128'(16'h0020));
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
